// File: rtl/dram_ddr_rdata_rcv_if.sv
// dram_ddr_rdata_rcv_if: read-return valid/ready handshake between the DDR read receiver and controller
interface dram_ddr_rdata_rcv_if #(
  parameter int DATA_W = 256,
  parameter int ECC_W  = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data_out;
  logic [ECC_W-1:0]  rd_ecc_out;
  modport master (output rd_valid, rd_data_out, rd_ecc_out, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data_out, rd_ecc_out, rd_last, output rd_ready);
endinterface

// File: rtl/dram_ddr_rdata_rcv.sv
// dram_ddr_rdata_rcv: captures DDR read beats, frames them into bursts against announced reads, and buffers them for read return
module dram_ddr_rdata_rcv #(
  parameter int DATA_W      = 256,
  parameter int ECC_W       = 32,
  parameter int DEPTH       = 4,
  parameter int BURST_BEATS = 2,
  parameter int MAX_PEND    = 7
) (
  input  logic                     clk,
  input  logic                     arst_l,
  input  logic                     io_dram_data_valid,
  input  logic [DATA_W-1:0]        io_dram_data_in,
  input  logic [ECC_W-1:0]         io_dram_ecc_in,
  input  logic                     dram_rd_expect,
  input  logic                     err_clr,
  dram_ddr_rdata_rcv_if.master     rd,
  output logic [2:0]               rd_pend_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     err_unexp,
  output logic                     err_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;
  localparam int EW = DATA_W + ECC_W + 1;
  logic              c_vld;
  logic [DATA_W-1:0] c_data;
  logic [ECC_W-1:0]  c_ecc;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [BW-1:0]     beat_cnt;
  logic qual, last, full, pop, push, done, inc, set_unexp, set_ovf;
  always_comb begin
    qual      = c_vld && rd_pend_cnt != 3'd0;
    last      = beat_cnt == BW'(BURST_BEATS - 1);
    full      = fifo_cnt == CW'(DEPTH);
    pop       = rd.rd_valid && rd.rd_ready;
    push      = qual && (!full || pop);
    done      = qual && last;
    inc       = dram_rd_expect && (rd_pend_cnt != 3'(MAX_PEND) || done);
    set_unexp = c_vld && rd_pend_cnt == 3'd0;
    set_ovf   = (qual && full && !pop) || (dram_rd_expect && !inc);
  end
  assign rd.rd_valid = fifo_cnt != '0;
  // Head is masked while empty so outputs read zero out of reset even though storage is not cleared
  assign {rd.rd_data_out, rd.rd_ecc_out, rd.rd_last} = rd.rd_valid ? mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {c_data, c_ecc, last};
  end
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      c_vld       <= 1'b0;
      c_data      <= '0;
      c_ecc       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fifo_cnt    <= '0;
      beat_cnt    <= '0;
      rd_pend_cnt <= '0;
      err_unexp   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      c_vld       <= io_dram_data_valid;
      c_data      <= io_dram_data_in;
      c_ecc       <= io_dram_ecc_in;
      wptr        <= push ? wptr + AW'(1) : wptr;
      rptr        <= pop ? rptr + AW'(1) : rptr;
      fifo_cnt    <= (push && !pop) ? fifo_cnt + CW'(1) : (pop && !push) ? fifo_cnt - CW'(1) : fifo_cnt;
      // Dropped beats still advance framing so later bursts stay aligned
      beat_cnt    <= qual ? (last ? '0 : beat_cnt + BW'(1)) : beat_cnt;
      rd_pend_cnt <= (inc && !done) ? rd_pend_cnt + 3'd1 : (done && !inc) ? rd_pend_cnt - 3'd1 : rd_pend_cnt;
      err_unexp   <= set_unexp || (err_unexp && !err_clr);
      err_ovf     <= set_ovf || (err_ovf && !err_clr);
    end
  end
endmodule

// File: tb/tb_dram_ddr_rdata_rcv.sv
// tb_dram_ddr_rdata_rcv: scoreboard bench for the DDR read-data receiver
module tb_dram_ddr_rdata_rcv;
  localparam int DATA_W = 256;
  localparam int ECC_W  = 32;
  localparam int EW     = DATA_W + ECC_W + 1;
  logic              clk = 1'b0;
  logic              arst_l;
  logic              io_valid;
  logic [DATA_W-1:0] io_data;
  logic [ECC_W-1:0]  io_ecc;
  logic              expect_p;
  logic              err_clr;
  logic [2:0]        rd_pend_cnt;
  logic [2:0]        fifo_cnt;
  logic              err_unexp, err_ovf;
  logic [EW-1:0]     sb[$];
  int checks = 0;
  int errors = 0;

  dram_ddr_rdata_rcv_if #(.DATA_W(DATA_W), .ECC_W(ECC_W)) rd_if ();

  dram_ddr_rdata_rcv #(.DATA_W(DATA_W), .ECC_W(ECC_W), .DEPTH(4), .BURST_BEATS(2), .MAX_PEND(7)) dut (
    .clk(clk),
    .arst_l(arst_l),
    .io_dram_data_valid(io_valid),
    .io_dram_data_in(io_data),
    .io_dram_ecc_in(io_ecc),
    .dram_rd_expect(expect_p),
    .err_clr(err_clr),
    .rd(rd_if.slave),
    .rd_pend_cnt(rd_pend_cnt),
    .fifo_cnt(fifo_cnt),
    .err_unexp(err_unexp),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic [ECC_W-1:0] e, input logic exp_last, input logic keep);
    if (keep) sb.push_back({d, e, exp_last});
    io_valid = 1'b1;
    io_data  = d;
    io_ecc   = e;
    tick();
    io_valid = 1'b0;
  endtask

  task automatic pulse_expect();
    expect_p = 1'b1;
    tick();
    expect_p = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rd_if.rd_valid, rd_if.rd_last, fifo_cnt, rd_pend_cnt, err_unexp, err_ovf} !== '0 || rd_if.rd_data_out !== '0 || rd_if.rd_ecc_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b cnt=%0d pend=%0d unexp=%0b ovf=%0b required all 0", rd_if.rd_valid, fifo_cnt, rd_pend_cnt, err_unexp, err_ovf);
    end
    tick();
    arst_l = 1'b1;
    tick();
  endtask

  task automatic test_single_burst();
    rd_if.rd_ready = 1'b1;
    pulse_expect();
    @(negedge clk);
    checks++;
    if (rd_pend_cnt !== 3'd1) begin errors++; $display("FAIL single_pend_up got %0d required 1", rd_pend_cnt); end
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b1);
    beat(rnd_data(), ECC_W'($urandom), 1'b1, 1'b1);
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (rd_pend_cnt !== 3'd0 || err_unexp !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL single_done pend=%0d unexp=%0b ovf=%0b required 0 0 0", rd_pend_cnt, err_unexp, err_ovf);
    end
    checks++;
    if (sb.size() != 0 || fifo_cnt !== 3'd0) begin errors++; $display("FAIL single_drain left=%0d cnt=%0d required 0 0", sb.size(), fifo_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] hold;
    tick();
    rd_if.rd_ready = 1'b0;
    expect_p = 1'b1;
    repeat (3) tick();
    expect_p = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) beat(rnd_data(), ECC_W'($urandom), 1'(i % 2), i < 4);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd4 || rd_if.rd_valid !== 1'b1) begin errors++; $display("FAIL bp_full cnt=%0d valid=%0b required 4 1", fifo_cnt, rd_if.rd_valid); end
    checks++;
    if (err_ovf !== 1'b1 || rd_pend_cnt !== 3'd0) begin errors++; $display("FAIL bp_ovf ovf=%0b pend=%0d required 1 0", err_ovf, rd_pend_cnt); end
    hold = rd_if.rd_data_out;
    tick();
    @(negedge clk);
    checks++;
    if (rd_if.rd_data_out !== hold) begin errors++; $display("FAIL bp_hold got %h required %h", rd_if.rd_data_out[31:0], hold[31:0]); end
    tick();
    rd_if.rd_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || fifo_cnt !== 3'd0) begin errors++; $display("FAIL bp_drain left=%0d cnt=%0d required 0 0", sb.size(), fifo_cnt); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_clr ovf=%0b required 0", err_ovf); end
  endtask

  task automatic test_unexpected();
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (err_unexp !== 1'b1 || fifo_cnt !== 3'd0 || rd_pend_cnt !== 3'd0) begin
      errors++; $display("FAIL unexp_flag unexp=%0b cnt=%0d pend=%0d required 1 0 0", err_unexp, fifo_cnt, rd_pend_cnt);
    end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_clr unexp=%0b required 0", err_unexp); end
  endtask

  task automatic test_simultaneous();
    tick();
    pulse_expect();
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b1);
    beat(rnd_data(), ECC_W'($urandom), 1'b1, 1'b1);
    pulse_expect();
    @(negedge clk);
    checks++;
    if (rd_pend_cnt !== 3'd1) begin errors++; $display("FAIL sim_pend got %0d required 1", rd_pend_cnt); end
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sim_drain left=%0d required 0", sb.size()); end
    tick();
    pulse_expect();
    pulse_expect();
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(rnd_data(), ECC_W'($urandom), 1'(i % 2), 1'b1);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd4) begin errors++; $display("FAIL sim_full cnt=%0d required 4", fifo_cnt); end
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b1);
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd4 || err_ovf !== 1'b0) begin errors++; $display("FAIL sim_pushpop cnt=%0d ovf=%0b required 4 0", fifo_cnt, err_ovf); end
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b1, 1'b1);
    rd_if.rd_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || fifo_cnt !== 3'd0 || rd_pend_cnt !== 3'd0) begin
      errors++; $display("FAIL sim_final left=%0d cnt=%0d pend=%0d required 0 0 0", sb.size(), fifo_cnt, rd_pend_cnt);
    end
  endtask

  task automatic test_pend_sat();
    tick();
    expect_p = 1'b1;
    repeat (8) tick();
    expect_p = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_pend_cnt !== 3'd7 || err_ovf !== 1'b1) begin errors++; $display("FAIL pend_sat pend=%0d ovf=%0b required 7 1", rd_pend_cnt, err_ovf); end
  endtask

  task automatic test_reset_mid_burst();
    tick();
    rd_if.rd_ready = 1'b0;
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (rd_if.rd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre valid=%0b required 1", rd_if.rd_valid); end
    #2;
    arst_l = 1'b0;
    #1;
    checks++;
    if ({rd_if.rd_valid, rd_if.rd_last, fifo_cnt, rd_pend_cnt, err_unexp, err_ovf} !== '0 || rd_if.rd_data_out !== '0 || rd_if.rd_ecc_out !== '0) begin
      errors++; $display("FAIL rst_async valid=%0b cnt=%0d pend=%0d ovf=%0b required all 0", rd_if.rd_valid, fifo_cnt, rd_pend_cnt, err_ovf);
    end
    tick();
    arst_l = 1'b1;
    tick();
    rd_if.rd_ready = 1'b1;
    pulse_expect();
    tick();
    beat(rnd_data(), ECC_W'($urandom), 1'b0, 1'b1);
    beat(rnd_data(), ECC_W'($urandom), 1'b1, 1'b1);
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || rd_pend_cnt !== 3'd0 || err_unexp !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_after left=%0d pend=%0d unexp=%0b ovf=%0b required 0 0 0 0", sb.size(), rd_pend_cnt, err_unexp, err_ovf);
    end
  endtask

  initial begin
    arst_l = 1'b0;
    io_valid = 1'b0;
    io_data = '0;
    io_ecc = '0;
    expect_p = 1'b0;
    err_clr = 1'b0;
    rd_if.rd_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rd_if.rd_valid && rd_if.rd_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL sb_extra got data=%h last=%0b required no beat", rd_if.rd_data_out[31:0], rd_if.rd_last);
          end else if ({rd_if.rd_data_out, rd_if.rd_ecc_out, rd_if.rd_last} !== sb[0]) begin
            errors++; $display("FAIL sb_beat got data=%h ecc=%h last=%0b required data=%h ecc=%h last=%0b",
              rd_if.rd_data_out[31:0], rd_if.rd_ecc_out, rd_if.rd_last, sb[0][EW-1 -: 32], sb[0][ECC_W:1], sb[0][0]);
            void'(sb.pop_front());
          end else void'(sb.pop_front());
        end
      end
    join_none
    repeat (2) @(posedge clk);
    test_reset();
    test_single_burst();
    test_backpressure();
    test_unexpected();
    test_simultaneous();
    test_pend_sat();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_ddr_rdata_rcv.md
Name: dram_ddr_rdata_rcv

Overview:
Controller-side receiver for DDR read data coming back from the south pad repeater (io_dram_data_valid / io_dram_data_in / io_dram_ecc_in).
- Registers incoming beats and checks them against reads the controller has announced.
- Groups beats into bursts, marking the last beat of each.
- Buffers beats in a small FIFO and hands them to the DRAM controller's read-return logic over a valid/ready handshake.
- Flags unexpected beats and overflow conditions.

Parameters:
DATA_W, 256, read data width per beat
ECC_W, 32, ECC width per beat
DEPTH, 4, FIFO entries (power of 2, >=2)
BURST_BEATS, 2, beats per read burst (power of 2, >=1)
MAX_PEND, 7, maximum outstanding announced bursts

Ports:
clk  input  1  controller clock
arst_l  input  1  asynchronous active-low reset
io_dram_data_valid  input  1  read beat present on pads this cycle
io_dram_data_in  input  DATA_W  read data beat
io_dram_ecc_in  input  ECC_W  ECC for beat
dram_rd_expect  input  1  pulse: controller issued one read burst
rd_ready  input  1  consumer accepts head beat
err_clr  input  1  clears sticky error flags
rd_valid  output  1  FIFO head valid
rd_data_out  output  DATA_W  head data
rd_ecc_out  output  ECC_W  head ECC
rd_last  output  1  head is final beat of its burst
rd_pend_cnt  output  3  outstanding bursts not yet fully captured
fifo_cnt  output  log2(DEPTH)+1  FIFO occupancy
err_unexp  output  1  sticky: beat arrived with rd_pend_cnt==0
err_ovf  output  1  sticky: beat dropped because FIFO full, or expect at MAX_PEND

Behaviour:
- Clock and reset: single clock clk. arst_l is asynchronous, active-low.
- Reset values (arst_l low): all outputs 0; capture register, FIFO pointers, beat counter and pending counter cleared; FIFO contents discarded.
- Reset mid-burst: the partial burst is lost, with no error. The beat counter restarts at 0.

Capture stage:
- Flop stage c_vld/c_data/c_ecc loads io_dram_data_valid/data/ecc every cycle.

Qualification (uses c_vld and the current rd_pend_cnt):
- If rd_pend_cnt==0: drop the beat, set err_unexp, beat counter unchanged.
- Else if FIFO full, after counting this cycle's pop (a pop on the same cycle frees a slot): drop the beat and set err_ovf. The beat counter still advances, so burst framing stays aligned.
- Else: write {data, ecc, last} into the FIFO. last = (beat_cnt==BURST_BEATS-1).

Beat counter:
- Increments on each qualified beat (rd_pend_cnt!=0), wraps to 0 after BURST_BEATS-1.
- A burst completes when a qualified beat has last=1.

Pending counter:
- +1 on dram_rd_expect.
- -1 on burst completion.
- Both in the same cycle: no change.
- dram_rd_expect when rd_pend_cnt==MAX_PEND and there is no completion that cycle: no increment, set err_ovf.
- dram_rd_expect takes effect on the next cycle. A beat captured in the same cycle as the first expect, with rd_pend_cnt==0, is unexpected.

Latency:
- A pad beat in cycle N is captured at the edge ending N and written at the edge ending N+1.
- rd_valid is high in cycle N+2 if the FIFO was empty.

FIFO:
- Synchronous, DEPTH entries. Head is presented combinationally from storage. rd_valid = !empty.
- Pop when rd_valid & rd_ready. rd_ready with rd_valid=0 is ignored.
- Push and pop in the same cycle: occupancy unchanged.
- Pointers wrap modulo DEPTH. fifo_cnt ranges 0..DEPTH.

Handshake:
- While rd_valid=1 and rd_ready=0, rd_data_out/rd_ecc_out/rd_last hold stable.
- No beat is reordered or duplicated.

Errors:
- err_unexp and err_ovf are sticky until err_clr.
- err_clr together with a new error event in the same cycle: the flag stays set (set wins).

Test Plan:
1. Single burst: one expect pulse in cycle 0; beats D0, D1 valid in cycles 3–4; rd_ready=1 -> rd_valid in cycles 5–6 with D0 (rd_last=0) then D1 (rd_last=1); rd_pend_cnt goes 0→1→0; no errors.
2. Backpressure: 3 expects; 6 back-to-back beats; rd_ready=0 -> fifo_cnt reaches 4, beats 5–6 dropped, err_ovf=1, rd_pend_cnt=0. Then rd_ready=1 -> exactly beats 1–4 delivered in order, with rd_last on beats 2 and 4.
3. Unexpected beat: no expect; one beat -> err_unexp=1, fifo_cnt stays 0, rd_pend_cnt=0. err_clr pulse -> err_unexp=0.
4. Simultaneous events: expect pulse in the same cycle the last beat of an earlier burst is captured -> rd_pend_cnt unchanged. FIFO full with push+pop in the same cycle -> no drop, fifo_cnt stays 4.
5. Pending saturation: 8 expect pulses with no data -> rd_pend_cnt=7, err_ovf=1.
6. Reset mid-burst: arst_l low after the first beat of a burst -> all outputs 0 immediately, asynchronously. After release, expect + 2 beats -> a normal burst with rd_last on the 2nd beat.
